oc_monitor: RTL and testbench
=============================

// Module: oc_monitor
// PURPOSE
//   Produces the 'oc' over-current shutdown input consumed by the H-bridge motor drivers (turn/drive blocks).
//   Watches two external current-sense comparators (channel A = PWMA bridge, B = PWMB bridge).
//   Each channel is synchronised, blanked after each PWM rising edge, and digitally filtered.
//   A trip forces oc high for a cooldown, then auto-retries; repeated trips latch a lockout until cleared.
// PARAMETERS
//   SYNC_STAGES   2           synchroniser flops on each sense input (>=2)
//   BLANK_CYC     200         cycles sense is ignored after a pwm_x rising edge (2 us @ 100 MHz)
//   FILTER_CYC    50          consecutive qualified high samples required to trip (>=1)
//   COOLDOWN_CYC  50_000_000  cycles oc stays high after a trip before retry (0.5 s)
//   MAX_RETRY     3           trips tolerated before lockout (>=1)
// PORTS
//   clock        in   1  system clock (100 MHz)
//   reset_n      in   1  asynchronous active-low reset
//   pwm_a        in   1  PWMA as driven to the bridge (clock domain)
//   pwm_b        in   1  PWMB as driven to the bridge (clock domain)
//   sense_a      in   1  channel A comparator, asynchronous, 1 = over current
//   sense_b      in   1  channel B comparator, asynchronous, 1 = over current
//   clear        in   1  single-cycle pulse: abort fault/lockout, zero retry_count
//   oc           out  1  registered shutdown request to motor drivers
//   trip_a       out  1  latched: channel A caused the last trip
//   trip_b       out  1  latched: channel B caused the last trip
//   lockout      out  1  1 = permanent fault, waits for clear
//   retry_count  out  RW number of trips since last clear, RW = $clog2(MAX_RETRY+1)
// BEHAVIOUR
//   Reset: state=RUN; oc, trip_a, trip_b, lockout = 0; retry_count = 0; all counters = 0.
//   Qualified sample (per channel): pwm_x = 1 and blank counter expired; pwm_x = 0 is never qualified.
//   Blank counter: loaded with BLANK_CYC on a pwm_x 0->1 edge; counts down to 0; a new edge reloads it.
//   Filter counter: +1 on each qualified cycle with synced sense = 1; any other cycle clears it to 0.
//   Trip: the filter reaches FILTER_CYC in RUN.
//     oc rises exactly SYNC_STAGES+FILTER_CYC cycles after the first clock edge that samples sense high.
//   FSM states: RUN, COOL, LOCK.
//   RUN -> COOL on a trip while retry_count+1 < MAX_RETRY.
//     retry_count is incremented; trip_x is set for each channel tripping that cycle and the other is cleared.
//   RUN -> LOCK on a trip while retry_count+1 == MAX_RETRY.
//     retry_count saturates at MAX_RETRY; lockout = 1.
//   COOL: counts COOLDOWN_CYC cycles.
//     Sense, filter and blank counters are held at 0; at terminal count -> RUN.
//   LOCK: held until clear.
//   oc = 1 in COOL and LOCK, 0 in RUN. The output is registered.
//   clear in COOL or LOCK: -> RUN next cycle; retry_count, lockout, trip_a and trip_b go to 0.
//   clear in RUN: retry_count = 0.
//   clear coincident with a trip in RUN: the trip wins, then retry_count = 1.
//   Both channels tripping in the same cycle: one trip is counted and trip_a = trip_b = 1.
//   Reset asserted mid-COOL or mid-LOCK: immediate return to reset values; the async assert drops oc.
//   All counters are unsigned, sized by $clog2(max+1), with no wrap. The cooldown counter is 26 bits at the defaults.
// CONFIGURATION
//   OC_AUTORETRY_EN defined: behaviour as above.
//   OC_AUTORETRY_EN undefined:
//     COOL does not exist; every trip goes RUN -> LOCK with retry_count = 1.
//     COOLDOWN_CYC and MAX_RETRY are ignored.
// STRUCTURE
//   motor_pkg: oc_state_t enum {RUN, COOL, LOCK}; CLK_HZ = 100_000_000; shared PWM period constant.
//   Sub-module oc_channel_filter (synchroniser + blank + filter, outputs a 1-cycle 'trip' strobe).
//     Instantiated twice; the FSM and status registers stay in oc_monitor.
// TESTING  (bench params: SYNC_STAGES=2, BLANK_CYC=4, FILTER_CYC=3, COOLDOWN_CYC=20, MAX_RETRY=2)
//   Reset: hold reset_n=0 with sense_a=1, pwm_a=1 -> oc=0, lockout=0, retry_count=0 throughout.
//   Blanking: pwm_a rises, sense_a=1 for only 4 cycles after the edge -> oc stays 0.
//   Trip latency: pwm_a=1 steady, sense_a 0->1 -> oc=1 exactly 5 cycles later; trip_a=1, trip_b=0, retry_count=1.
//   Cooldown/retry: after a trip, oc is high 20 cycles then 0.
//     A second trip -> lockout=1, retry_count=2, oc held high for 1000 cycles.
//   Clear: pulse clear in LOCK -> next cycle oc=0, lockout=0, retry_count=0, trip_a=0.
//   Glitch/simultaneous: sense_b high 2 cycles, low 1, high 2 -> no trip.
//     Then sense_a and sense_b rise together -> trip_a=trip_b=1, retry_count=1.
//   Without OC_AUTORETRY_EN: a first trip -> lockout=1 and oc stays high until clear.

Source files
------------

// File: rtl/motor_pkg.sv
// Shared types and constants for the motor-control blocks.
//   oc_state_t     : over-current monitor state (RUN, COOL, LOCK)
//   CLK_HZ         : system clock frequency
//   PWM_PERIOD_CYC : PWM period in system clock cycles
//   cnt_width()    : bit width of an unsigned counter that must reach max_val
package motor_pkg;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    COOL = 2'd1,
    LOCK = 2'd2
  } oc_state_t;

  localparam int CLK_HZ         = 100_000_000;
  localparam int PWM_FREQ_HZ    = 20_000;
  localparam int PWM_PERIOD_CYC = CLK_HZ / PWM_FREQ_HZ;

  // Never returns 0 so degenerate parameter values still give a legal vector.
  function automatic int cnt_width(input int max_val);
    return (max_val > 0) ? $clog2(max_val + 1) : 1;
  endfunction

endpackage

// File: rtl/oc_channel_filter.sv
// One current-sense channel: synchroniser, post-PWM-edge blanking and a
// consecutive-sample filter.
// Ports:
//   clock, reset_n : system clock, asynchronous active-low reset
//   pwm            : PWM level as driven to the bridge (clock domain)
//   sense          : asynchronous comparator output, 1 = over current
//   hold           : forces synchroniser, blank and filter counters to 0
//   trip           : registered 1-cycle strobe when the filter first reaches FILTER_CYC
module oc_channel_filter
  import motor_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int BLANK_CYC   = 200,
  parameter int FILTER_CYC  = 50
) (
  input  logic clock,
  input  logic reset_n,
  input  logic pwm,
  input  logic sense,
  input  logic hold,
  output logic trip
);

  localparam int BW = cnt_width(BLANK_CYC);
  localparam int FW = cnt_width(FILTER_CYC);

  localparam logic [BW-1:0] BLANK_LOAD  = BW'(BLANK_CYC);
  localparam logic [BW-1:0] BLANK_ONE   = BW'(1);
  localparam logic [BW-1:0] BLANK_ZERO  = {BW{1'b0}};
  localparam logic [FW-1:0] FILTER_MAX  = FW'(FILTER_CYC);
  localparam logic [FW-1:0] FILTER_LAST = FW'(FILTER_CYC - 1);
  localparam logic [FW-1:0] FILTER_ONE  = FW'(1);
  localparam logic [FW-1:0] FILTER_ZERO = {FW{1'b0}};

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   pwm_d_r;
  logic [BW-1:0]          blank_r;
  logic [BW-1:0]          blank_nxt_s;
  logic [FW-1:0]          filter_r;
  logic [FW-1:0]          filter_nxt_s;
  logic                   trip_r;
  logic                   trip_nxt_s;
  logic                   sense_sync_s;
  logic                   pwm_rise_s;
  logic                   qual_s;
  logic                   hit_s;

  // Synchroniser chain for the asynchronous comparator input
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_r <= {SYNC_STAGES{1'b0}};
    end else if (hold) begin
      sync_r <= {SYNC_STAGES{1'b0}};
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], sense};
    end
  end

  // Previous PWM level, tracked even while held so no stale edge appears on release
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pwm_d_r <= 1'b0;
    end else begin
      pwm_d_r <= pwm;
    end
  end

  // Qualification: PWM on, not the edge cycle itself, blanking expired
  always_comb begin
    sense_sync_s = sync_r[SYNC_STAGES-1];
    pwm_rise_s   = pwm & ~pwm_d_r;
    qual_s       = pwm & ~pwm_rise_s & (blank_r == BLANK_ZERO);
    hit_s        = qual_s & sense_sync_s;
  end

  // Next blank and filter counts plus trip strobe
  always_comb begin
    blank_nxt_s  = blank_r;
    filter_nxt_s = filter_r;
    trip_nxt_s   = 1'b0;
    if (hold) begin
      blank_nxt_s = BLANK_ZERO;
    end else if (pwm_rise_s) begin
      blank_nxt_s = BLANK_LOAD;
    end else if (blank_r != BLANK_ZERO) begin
      blank_nxt_s = blank_r - BLANK_ONE;
    end else begin
      blank_nxt_s = blank_r;
    end
    if (hold) begin
      filter_nxt_s = FILTER_ZERO;
    end else if (hit_s) begin
      // Saturate at FILTER_CYC; the strobe fires only on the arriving step
      if (filter_r == FILTER_MAX) begin
        filter_nxt_s = filter_r;
      end else begin
        filter_nxt_s = filter_r + FILTER_ONE;
      end
    end else begin
      filter_nxt_s = FILTER_ZERO;
    end
    trip_nxt_s = ~hold & hit_s & (filter_r == FILTER_LAST);
  end

  // Counter and strobe registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      blank_r  <= BLANK_ZERO;
      filter_r <= FILTER_ZERO;
      trip_r   <= 1'b0;
    end else begin
      blank_r  <= blank_nxt_s;
      filter_r <= filter_nxt_s;
      trip_r   <= trip_nxt_s;
    end
  end

  assign trip = trip_r;

endmodule

// File: rtl/oc_monitor.sv
// Over-current monitor producing the 'oc' shutdown request for the H-bridge
// drivers. Two sense channels (A = PWMA bridge, B = PWMB bridge) are filtered
// by oc_channel_filter; a trip forces oc high.
// Configuration macro OC_AUTORETRY_EN:
//   defined   : trip -> COOL for COOLDOWN_CYC cycles then retry; the
//               MAX_RETRY-th trip since clear latches LOCK.
//   undefined : every trip latches LOCK with retry_count = 1.
// Ports:
//   clock, reset_n   : system clock, asynchronous active-low reset
//   pwm_a, pwm_b     : PWM levels driven to the bridges
//   sense_a, sense_b : asynchronous comparator inputs, 1 = over current
//   clear            : 1-cycle pulse, aborts fault/lockout, zeroes retry_count
//   oc               : registered shutdown request
//   trip_a, trip_b   : channel(s) responsible for the last trip
//   lockout          : permanent fault, waits for clear
//   retry_count      : trips since last clear
module oc_monitor
  import motor_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int BLANK_CYC    = 200,
  parameter int FILTER_CYC   = 50,
  parameter int COOLDOWN_CYC = 50_000_000,
  parameter int MAX_RETRY    = 3
) (
  input  logic                           clock,
  input  logic                           reset_n,
  input  logic                           pwm_a,
  input  logic                           pwm_b,
  input  logic                           sense_a,
  input  logic                           sense_b,
  input  logic                           clear,
  output logic                           oc,
  output logic                           trip_a,
  output logic                           trip_b,
  output logic                           lockout,
  output logic [$clog2(MAX_RETRY+1)-1:0] retry_count
);

  localparam int RW = $clog2(MAX_RETRY + 1);
  localparam logic [RW-1:0] RETRY_ZERO = {RW{1'b0}};
  localparam logic [RW-1:0] RETRY_ONE  = RW'(1);

`ifdef OC_AUTORETRY_EN
  localparam int CW = cnt_width(COOLDOWN_CYC);
  localparam logic [CW-1:0] COOL_LAST  = CW'((COOLDOWN_CYC > 0) ? (COOLDOWN_CYC - 1) : 0);
  localparam logic [CW-1:0] COOL_ONE   = CW'(1);
  localparam logic [CW-1:0] COOL_ZERO  = {CW{1'b0}};
  localparam logic [RW-1:0] RETRY_LAST = RW'(MAX_RETRY - 1);
  localparam logic [RW-1:0] RETRY_MAX  = RW'(MAX_RETRY);

  logic [CW-1:0] cool_cnt_r;
  logic [CW-1:0] cool_cnt_nxt_s;
  logic [RW-1:0] retry_base_s;
`endif

  oc_state_t     state_r;
  oc_state_t     state_nxt_s;
  logic          oc_r;
  logic          oc_nxt_s;
  logic          trip_a_r;
  logic          trip_a_nxt_s;
  logic          trip_b_r;
  logic          trip_b_nxt_s;
  logic          lockout_r;
  logic          lockout_nxt_s;
  logic [RW-1:0] retry_r;
  logic [RW-1:0] retry_nxt_s;
  logic          chan_a_trip_s;
  logic          chan_b_trip_s;
  logic          trip_any_s;
  logic          hold_s;

`ifdef OC_AUTORETRY_EN
  assign hold_s = (state_r == COOL);
`else
  assign hold_s = 1'b0;
`endif

  oc_channel_filter #(
    .SYNC_STAGES (SYNC_STAGES),
    .BLANK_CYC   (BLANK_CYC),
    .FILTER_CYC  (FILTER_CYC)
  ) u_chan_a (
    .clock   (clock),
    .reset_n (reset_n),
    .pwm     (pwm_a),
    .sense   (sense_a),
    .hold    (hold_s),
    .trip    (chan_a_trip_s)
  );

  oc_channel_filter #(
    .SYNC_STAGES (SYNC_STAGES),
    .BLANK_CYC   (BLANK_CYC),
    .FILTER_CYC  (FILTER_CYC)
  ) u_chan_b (
    .clock   (clock),
    .reset_n (reset_n),
    .pwm     (pwm_b),
    .sense   (sense_b),
    .hold    (hold_s),
    .trip    (chan_b_trip_s)
  );

  assign trip_any_s = chan_a_trip_s | chan_b_trip_s;

`ifdef OC_AUTORETRY_EN
  // A clear arriving with a trip restarts the count from zero before counting the trip
  assign retry_base_s = clear ? RETRY_ZERO : retry_r;
`endif

  // Next-state and next-output logic
  always_comb begin
    state_nxt_s   = state_r;
    trip_a_nxt_s  = trip_a_r;
    trip_b_nxt_s  = trip_b_r;
    lockout_nxt_s = lockout_r;
    retry_nxt_s   = retry_r;
`ifdef OC_AUTORETRY_EN
    cool_cnt_nxt_s = cool_cnt_r;
`endif
    case (state_r)
      RUN: begin
        if (trip_any_s) begin
          trip_a_nxt_s = chan_a_trip_s;
          trip_b_nxt_s = chan_b_trip_s;
`ifdef OC_AUTORETRY_EN
          if (retry_base_s < RETRY_LAST) begin
            state_nxt_s    = COOL;
            retry_nxt_s    = retry_base_s + RETRY_ONE;
            cool_cnt_nxt_s = COOL_ZERO;
          end else begin
            state_nxt_s   = LOCK;
            retry_nxt_s   = RETRY_MAX;
            lockout_nxt_s = 1'b1;
          end
`else
          state_nxt_s   = LOCK;
          retry_nxt_s   = RETRY_ONE;
          lockout_nxt_s = 1'b1;
`endif
        end else if (clear) begin
          retry_nxt_s = RETRY_ZERO;
        end else begin
          retry_nxt_s = retry_r;
        end
      end
`ifdef OC_AUTORETRY_EN
      COOL: begin
        if (clear) begin
          state_nxt_s    = RUN;
          trip_a_nxt_s   = 1'b0;
          trip_b_nxt_s   = 1'b0;
          lockout_nxt_s  = 1'b0;
          retry_nxt_s    = RETRY_ZERO;
          cool_cnt_nxt_s = COOL_ZERO;
        end else if (cool_cnt_r == COOL_LAST) begin
          state_nxt_s    = RUN;
          cool_cnt_nxt_s = COOL_ZERO;
        end else begin
          cool_cnt_nxt_s = cool_cnt_r + COOL_ONE;
        end
      end
`endif
      LOCK: begin
        if (clear) begin
          state_nxt_s   = RUN;
          trip_a_nxt_s  = 1'b0;
          trip_b_nxt_s  = 1'b0;
          lockout_nxt_s = 1'b0;
          retry_nxt_s   = RETRY_ZERO;
        end else begin
          state_nxt_s = LOCK;
        end
      end
      default: begin
        // Unreachable encodings fail safe to a locked-out shutdown
        state_nxt_s   = LOCK;
        lockout_nxt_s = 1'b1;
      end
    endcase
    oc_nxt_s = (state_nxt_s != RUN);
  end

  // State and status registers; oc follows the next state so it is registered
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r   <= RUN;
      oc_r      <= 1'b0;
      trip_a_r  <= 1'b0;
      trip_b_r  <= 1'b0;
      lockout_r <= 1'b0;
      retry_r   <= RETRY_ZERO;
    end else begin
      state_r   <= state_nxt_s;
      oc_r      <= oc_nxt_s;
      trip_a_r  <= trip_a_nxt_s;
      trip_b_r  <= trip_b_nxt_s;
      lockout_r <= lockout_nxt_s;
      retry_r   <= retry_nxt_s;
    end
  end

`ifdef OC_AUTORETRY_EN
  // Cooldown counter
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cool_cnt_r <= COOL_ZERO;
    end else begin
      cool_cnt_r <= cool_cnt_nxt_s;
    end
  end
`endif

  assign oc          = oc_r;
  assign trip_a      = trip_a_r;
  assign trip_b      = trip_b_r;
  assign lockout     = lockout_r;
  assign retry_count = retry_r;

endmodule

// File: tb/tb_oc_monitor.sv
// Scoreboard bench for oc_monitor. Expected status words
// {oc, trip_a, trip_b, lockout, retry_count[1:0]} are queued when stimulus is
// driven and popped/compared one per clock, sampled 1 time unit after the edge.
// Works with or without OC_AUTORETRY_EN defined.
module tb_oc_monitor;

  logic       clock;
  logic       reset_n;
  logic       pwm_a;
  logic       pwm_b;
  logic       sense_a;
  logic       sense_b;
  logic       clear;
  logic       oc;
  logic       trip_a;
  logic       trip_b;
  logic       lockout;
  logic [1:0] retry_count;
  logic [5:0] status_s;

  typedef struct {
    string      tag;
    logic [5:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   vec_cnt;
  int   err_cnt;

`ifdef OC_AUTORETRY_EN
  localparam logic [5:0] ST_TRIP_A = 6'b110001;
  localparam logic [5:0] ST_BOTH   = 6'b111001;
`else
  localparam logic [5:0] ST_TRIP_A = 6'b110101;
  localparam logic [5:0] ST_BOTH   = 6'b111101;
`endif
  localparam logic [5:0] ST_IDLE = 6'b000000;

  oc_monitor #(
    .SYNC_STAGES  (2),
    .BLANK_CYC    (4),
    .FILTER_CYC   (3),
    .COOLDOWN_CYC (20),
    .MAX_RETRY    (2)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .pwm_a       (pwm_a),
    .pwm_b       (pwm_b),
    .sense_a     (sense_a),
    .sense_b     (sense_b),
    .clear       (clear),
    .oc          (oc),
    .trip_a      (trip_a),
    .trip_b      (trip_b),
    .lockout     (lockout),
    .retry_count (retry_count)
  );

  assign status_s = {oc, trip_a, trip_b, lockout, retry_count};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_vec(input string tag, input logic [5:0] obs, input logic [5:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %b, want %b (oc,ta,tb,lock,rc) at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push_exp(input string tag, input logic [5:0] val, input int n);
    exp_t e;
    e.tag = tag;
    e.val = val;
    for (int i = 0; i < n; i++) exp_q.push_back(e);
  endtask

  task automatic pop_chk();
    exp_t e;
    if (exp_q.size() == 0) begin
      check_vec("sb_underflow", 6'(exp_q.size()), 6'd1);
    end else begin
      e = exp_q.pop_front();
      check_vec(e.tag, status_s, e.val);
    end
  endtask

  task automatic run_pop(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      pop_chk();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] pat;
    vec_cnt = 0;
    err_cnt = 0;
    reset_n = 1'b0;
    pwm_a   = 1'b1;
    pwm_b   = 1'b0;
    sense_a = 1'b1;
    sense_b = 1'b0;
    clear   = 1'b0;

    // Reset held with sense and pwm active: outputs stay idle
    push_exp("reset_hold", ST_IDLE, 5);
    run_pop(5);
    sense_a = 1'b0;
    pwm_a   = 1'b0;
    reset_n = 1'b1;
    push_exp("post_reset", ST_IDLE, 3);
    run_pop(3);

    // Sense high only during the blanking window after a PWM rising edge
    pwm_a   = 1'b1;
    sense_a = 1'b1;
    push_exp("blanking", ST_IDLE, 12);
    run_pop(4);
    sense_a = 1'b0;
    run_pop(8);

    // Trip latency: oc must rise on the 6th sample (5 edges after first sampling edge)
    sense_a = 1'b1;
    push_exp("trip_lat_pre", ST_IDLE, 5);
    push_exp("trip_lat", ST_TRIP_A, 1);
    run_pop(6);
    sense_a = 1'b0;

`ifdef OC_AUTORETRY_EN
    push_exp("cool_hold", ST_TRIP_A, 19);
    push_exp("cool_end", 6'b010001, 1);
    run_pop(20);
    sense_a = 1'b1;
    push_exp("retry2_pre", 6'b010001, 5);
    push_exp("retry2_lock", 6'b110110, 1);
    run_pop(6);
    sense_a = 1'b0;
    push_exp("lock_hold", 6'b110110, 1000);
    run_pop(1000);
`else
    push_exp("lock_hold", ST_TRIP_A, 1000);
    run_pop(1000);
`endif

    // Clear in LOCK returns everything to idle on the next cycle
    clear = 1'b1;
    push_exp("clear_lock", ST_IDLE, 1);
    run_pop(1);
    clear = 1'b0;

    // Glitchy sense_b (1,1,0,1,1) never satisfies the 3-sample filter
    pwm_b = 1'b1;
    push_exp("pwm_b_blank", ST_IDLE, 8);
    run_pop(8);
    pat = 5'b11011;
    for (int i = 4; i >= 0; i--) begin
      sense_b = pat[i];
      push_exp("glitch", ST_IDLE, 1);
      run_pop(1);
    end
    sense_b = 1'b0;
    push_exp("glitch_tail", ST_IDLE, 6);
    run_pop(6);

    // Simultaneous trip on both channels: one trip counted, both flags set
    sense_a = 1'b1;
    sense_b = 1'b1;
    push_exp("both_pre", ST_IDLE, 5);
    push_exp("both_trip", ST_BOTH, 1);
    run_pop(6);
    sense_a = 1'b0;
    sense_b = 1'b0;

`ifdef OC_AUTORETRY_EN
    push_exp("both_cool", ST_BOTH, 19);
    push_exp("both_cool_end", 6'b011001, 1);
    run_pop(20);
    // Clear coincident with a trip: trip wins and count restarts at 1 (COOL, not LOCK)
    sense_a = 1'b1;
    push_exp("clr_trip_pre", 6'b011001, 5);
    run_pop(5);
    clear = 1'b1;
    push_exp("clr_trip", 6'b110001, 1);
    run_pop(1);
    clear   = 1'b0;
    sense_a = 1'b0;
    push_exp("clr_trip_cool", 6'b110001, 19);
    push_exp("clr_trip_end", 6'b010001, 1);
    run_pop(20);
    // Clear in RUN zeroes only the retry count
    clear = 1'b1;
    push_exp("clear_run", 6'b010000, 1);
    run_pop(1);
    clear = 1'b0;
    // Enter COOL again for the mid-cooldown reset
    sense_a = 1'b1;
    push_exp("cool2_pre", 6'b010000, 5);
    push_exp("cool2_trip", 6'b110001, 1);
    run_pop(6);
    sense_a = 1'b0;
    push_exp("cool2_hold", 6'b110001, 3);
    run_pop(3);
`else
    clear = 1'b1;
    push_exp("clear_lock2", ST_IDLE, 1);
    run_pop(1);
    clear = 1'b0;
    // Clear coincident with a trip: trip wins, retry_count = 1
    sense_a = 1'b1;
    push_exp("clr_trip_pre", ST_IDLE, 5);
    run_pop(5);
    clear = 1'b1;
    push_exp("clr_trip", ST_TRIP_A, 1);
    run_pop(1);
    clear   = 1'b0;
    sense_a = 1'b0;
    push_exp("clr_trip_hold", ST_TRIP_A, 3);
    run_pop(3);
`endif

    // Asynchronous reset mid-fault drops oc before the next clock edge
    #2;
    reset_n = 1'b0;
    sense_a = 1'b1;
    #1;
    push_exp("rst_async", ST_IDLE, 1);
    pop_chk();
    push_exp("rst_hold", ST_IDLE, 3);
    run_pop(3);
    sense_a = 1'b0;
    reset_n = 1'b1;
    push_exp("rst_release", ST_IDLE, 5);
    run_pop(5);

    check_vec("sb_drain", 6'(exp_q.size()), 6'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
